// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - video timing bundle between the generator and drawing blocks
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hblnk;
  logic          vblnk;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          sol;
  logic          sof;

  modport master (
    output hcount, vcount, hblnk, vblnk, hsync, vsync, de, sol, sof
  );

  modport slave (
    input hcount, vcount, hblnk, vblnk, hsync, vsync, de, sol, sof
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VESA-style timing generator with pixel clock-enable
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int CW        = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  vga_timing_gen_if.master vid
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject degenerate modes and counters too narrow for the chosen totals
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CW == 0) begin : g_zero_param
    $error("vga_timing_gen: timing parameters and CW must be non-zero");
  end
  if (HTOTAL > (2 ** CW) || VTOTAL > (2 ** CW)) begin : g_cw_too_small
    $error("vga_timing_gen: HTOTAL/VTOTAL exceed counter range 2^CW");
  end

  localparam logic [CW-1:0] H_LAST    = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ACTIVE = (HSYNC_POL != 0);
  localparam logic          VS_ACTIVE = (VSYNC_POL != 0);

  logic          h_last;
  logic          v_last;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          hblnk_next;
  logic          vblnk_next;
  logic          hsync_next;
  logic          vsync_next;

  // Next counter position and the flags decoded from it, so flags land with their counts
  always_comb begin
    h_last     = (vid.hcount == H_LAST);
    v_last     = (vid.vcount == V_LAST);
    h_next     = h_last ? '0 : vid.hcount + CW'(1);
    v_next     = vid.vcount;
    if (h_last) begin
      v_next = v_last ? '0 : vid.vcount + CW'(1);
    end
    hblnk_next = (h_next >= H_ACT);
    vblnk_next = (v_next >= V_ACT);
    hsync_next = ((h_next >= HS_START) && (h_next < HS_END)) ? HS_ACTIVE : ~HS_ACTIVE;
    vsync_next = ((v_next >= VS_START) && (v_next < VS_END)) ? VS_ACTIVE : ~VS_ACTIVE;
  end

  // Registered timing state; advances on ce, strobes only on a ce-qualified wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid.hcount <= '0;
      vid.vcount <= '0;
      vid.hblnk  <= 1'b0;
      vid.vblnk  <= 1'b0;
      vid.hsync  <= ~HS_ACTIVE;
      vid.vsync  <= ~VS_ACTIVE;
      vid.de     <= 1'b1;
      vid.sol    <= 1'b0;
      vid.sof    <= 1'b0;
    end else if (ce) begin
      vid.hcount <= h_next;
      vid.vcount <= v_next;
      vid.hblnk  <= hblnk_next;
      vid.vblnk  <= vblnk_next;
      vid.hsync  <= hsync_next;
      vid.vsync  <= vsync_next;
      vid.de     <= ~hblnk_next & ~vblnk_next;
      vid.sol    <= h_last;
      vid.sof    <= h_last & v_last;
    end else begin
      vid.sol    <= 1'b0;
      vid.sof    <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 VGA timing controller.
- Generates horizontal/vertical pixel counters, blanking, sync, data-enable and frame/line strobes for any VESA-style mode, selected by parameters.
- Adds a pixel clock-enable so one fast system clock can drive slower pixel rates, plus programmable sync polarity.
- Sits at the head of the video pipeline; drawing blocks (background, paddles, ball, score) consume its outputs.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BP, 23, vertical back porch (lines)
HSYNC_POL, 1, active level of hsync (1 = positive)
VSYNC_POL, 1, active level of vsync
CW, 11, counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ce  in  1  pixel clock-enable; timing advances only when high
hcount  out  CW  pixel index in line, 0..HTOTAL-1
vcount  out  CW  line index in frame, 0..VTOTAL-1
hblnk  out  1  high while hcount >= H_ACTIVE
vblnk  out  1  high while vcount >= V_ACTIVE
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
de  out  1  data enable = !hblnk & !vblnk
sol  out  1  start-of-line strobe, one clk wide
sof  out  1  start-of-frame strobe, one clk wide

Behaviour:
- Interface: single clock clk; reset rst is asynchronous and active-high.
- Derived: HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); VTOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
- Elaboration error if any parameter is 0 or HTOTAL/VTOTAL exceed 2^CW.
- All outputs are registered. Each output is decoded from the next counter values, so every flag is cycle-aligned with the hcount/vcount it describes. There is zero latency between the counters and the flags.
- Reset values: hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=!HSYNC_POL, vsync=!VSYNC_POL, sol=0, sof=0.
- On each clk with ce=1:
  - hcount increments. At HTOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps to 0 after VTOTAL-1, which happens only on the hcount wrap.
- On each clk with ce=0: counters, blank, sync and de hold their values; sol and sof are 0.
- hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], inactive otherwise.
- vsync is active for whole lines with vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes only together with the hcount 0 transition.
- sol is high for exactly one clk: the cycle in which hcount has just become 0 via a ce-qualified wrap.
- sof is high in that same cycle only when vcount has also just become 0.
- No strobe is produced by reset release itself. The first sof appears after one full frame of ce cycles.
- Async rst asserted mid-frame: all outputs return to their reset values immediately.
- After rst deasserts, counting restarts from (0,0) on the first ce=1 edge.
- Counters never exceed HTOTAL-1 / VTOTAL-1 under any ce pattern.

Test Plan:
- Reset, then ce=1 continuously, default params:
  - hcount 0..1055 then wraps to 0.
  - hblnk rises at hcount=800 and falls at hcount=0.
  - hsync high for hcount 840..967.
- Full frame, ce=1:
  - vblnk high for vcount 600..627.
  - vsync high for vcount 601..604.
  - sof pulses every 663168 clks, first at clk 663168 after reset release.
  - sol pulses every 1056 clks.
  - de high exactly 480000 clks per frame.
- ce toggling 1,0,1,0:
  - counters advance every second clk.
  - sol/sof stay one clk wide.
  - frame period doubles to 1326336 clks.
- Tiny mode (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=0, VSYNC_POL=0):
  - HTOTAL=8, VTOTAL=6.
  - hsync low at hcount 5..6.
  - vsync low on vcount 4.
  - wraps exact.
- Async rst pulsed mid-line (hcount=500, vcount=300), no clk edge during the pulse:
  - outputs immediately show reset values.
  - counting resumes from 0 after release.
- ce held low at hcount=1055, vcount=627 for 10 clks:
  - all outputs frozen, no strobes.
  - the next ce produces (0,0) with sol=sof=1 for one clk.
